// File: rtl/fft_radix2_butterfly.sv
// Two-stage radix-2 DIT butterfly: S1 forms A+P / A-P at 35 bits, S2 applies
// optional round-half-up halving and clamps to 32 bits, with ready/valid on both sides.
module fft_radix2_butterfly #(
  parameter int N_PAIRS = 512,
  parameter int CNT_W   = 9
) (
  input  logic               sys_clk_i,
  input  logic               rst_n_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic signed [31:0] a_real_i,
  input  logic signed [31:0] a_imag_i,
  input  logic signed [33:0] p_real_i,
  input  logic signed [33:0] p_imag_i,
  input  logic               scale_i,
  input  logic               clr_sat_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic signed [31:0] x0_real_o,
  output logic signed [31:0] x0_imag_o,
  output logic signed [31:0] x1_real_o,
  output logic signed [31:0] x1_imag_o,
  output logic               out_last_o,
  output logic               sat_o
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_PAIRS - 1);

  logic                s1_valid;
  logic                s2_valid;
  logic                s1_adv;
  logic                s2_adv;
  logic                in_xfer;
  logic                out_xfer;
  logic signed [34:0]  a_re_x;
  logic signed [34:0]  a_im_x;
  logic signed [34:0]  p_re_x;
  logic signed [34:0]  p_im_x;
  logic signed [34:0]  s1_sum_re;
  logic signed [34:0]  s1_sum_im;
  logic signed [34:0]  s1_dif_re;
  logic signed [34:0]  s1_dif_im;
  logic                s1_scale;
  logic [31:0]         v_x0_re;
  logic [31:0]         v_x0_im;
  logic [31:0]         v_x1_re;
  logic [31:0]         v_x1_im;
  logic                hit_x0_re;
  logic                hit_x0_im;
  logic                hit_x1_re;
  logic                hit_x1_im;
  logic                pair_sat;
  logic                s2_sat;
  logic [CNT_W-1:0]    cnt;

  // Halving uses a 36-bit intermediate so x+1 can never wrap; bit 32 flags a clamp.
  function automatic logic [32:0] scale_sat(input logic signed [34:0] x, input logic sc);
    logic signed [35:0] xe;
    logic signed [35:0] v;
    logic [32:0]        r;
    xe = {x[34], x};
    if (sc) v = (xe + 36'sd1) >>> 1;
    else    v = xe;
    if (v > 36'sh0_7FFF_FFFF)      r = {1'b1, 32'h7FFF_FFFF};
    else if (v < -36'sh0_8000_0000) r = {1'b1, 32'h8000_0000};
    else                           r = {1'b0, v[31:0]};
    return r;
  endfunction

  assign a_re_x = {{3{a_real_i[31]}}, a_real_i};
  assign a_im_x = {{3{a_imag_i[31]}}, a_imag_i};
  assign p_re_x = {p_real_i[33], p_real_i};
  assign p_im_x = {p_imag_i[33], p_imag_i};

  assign s2_adv     = !s2_valid || out_ready_i;
  assign s1_adv     = !s1_valid || s2_adv;
  assign in_ready_o = s1_adv;
  assign in_xfer    = in_valid_i && s1_adv;
  assign out_xfer   = s2_valid && out_ready_i;

  assign out_valid_o = s2_valid;
  assign out_last_o  = s2_valid && (cnt == LAST_CNT);

  always_comb begin
    {hit_x0_re, v_x0_re} = scale_sat(s1_sum_re, s1_scale);
    {hit_x0_im, v_x0_im} = scale_sat(s1_sum_im, s1_scale);
    {hit_x1_re, v_x1_re} = scale_sat(s1_dif_re, s1_scale);
    {hit_x1_im, v_x1_im} = scale_sat(s1_dif_im, s1_scale);
    pair_sat = hit_x0_re | hit_x0_im | hit_x1_re | hit_x1_im;
  end

  always_ff @(posedge sys_clk_i) begin
    if (!rst_n_i) begin
      s1_valid  <= 1'b0;
      s1_sum_re <= '0;
      s1_sum_im <= '0;
      s1_dif_re <= '0;
      s1_dif_im <= '0;
      s1_scale  <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid_i;
      if (in_xfer) begin
        s1_sum_re <= a_re_x + p_re_x;
        s1_sum_im <= a_im_x + p_im_x;
        s1_dif_re <= a_re_x - p_re_x;
        s1_dif_im <= a_im_x - p_im_x;
        s1_scale  <= scale_i;
      end
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (!rst_n_i) begin
      s2_valid  <= 1'b0;
      s2_sat    <= 1'b0;
      x0_real_o <= '0;
      x0_imag_o <= '0;
      x1_real_o <= '0;
      x1_imag_o <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        x0_real_o <= v_x0_re;
        x0_imag_o <= v_x0_im;
        x1_real_o <= v_x1_re;
        x1_imag_o <= v_x1_im;
        s2_sat    <= pair_sat;
      end
    end
  end

  // Frame position and sticky flag only move on an accepted output; set beats clear.
  always_ff @(posedge sys_clk_i) begin
    if (!rst_n_i) begin
      cnt   <= '0;
      sat_o <= 1'b0;
    end else begin
      if (out_xfer) begin
        if (cnt == LAST_CNT) cnt <= '0;
        else                 cnt <= cnt + CNT_W'(1);
      end
      if (out_xfer && s2_sat) sat_o <= 1'b1;
      else if (clr_sat_i)     sat_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_radix2_butterfly.sv
// Self-checking bench: directed vector table, sticky-flag and reset sequences,
// and randomized streams checked against an arithmetic reference model.
module tb_fft_radix2_butterfly;

  localparam int NP = 4;
  localparam int CW = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] a_re;
  logic signed [31:0] a_im;
  logic signed [33:0] p_re;
  logic signed [33:0] p_im;
  logic               scale;
  logic               clr_sat;
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] x0_re;
  logic signed [31:0] x0_im;
  logic signed [31:0] x1_re;
  logic signed [31:0] x1_im;
  logic               out_last;
  logic               sat;

  int     n_checks = 0;
  int     n_fail = 0;
  int     out_count = 0;
  bit     sat_model = 0;

  typedef struct {
    longint x0re;
    longint x0im;
    longint x1re;
    longint x1im;
    bit     sat;
  } res_t;

  typedef struct {
    logic signed [31:0] are;
    logic signed [31:0] aim;
    logic signed [33:0] pre;
    logic signed [33:0] pim;
    bit                 sc;
    longint             x0re;
    longint             x0im;
    longint             x1re;
    longint             x1im;
    bit                 sat_after;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  fft_radix2_butterfly #(.N_PAIRS(NP), .CNT_W(CW)) dut (
    .sys_clk_i  (clk),
    .rst_n_i    (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .a_real_i   (a_re),
    .a_imag_i   (a_im),
    .p_real_i   (p_re),
    .p_imag_i   (p_im),
    .scale_i    (scale),
    .clr_sat_i  (clr_sat),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .x0_real_o  (x0_re),
    .x0_imag_o  (x0_im),
    .x1_real_o  (x1_re),
    .x1_imag_o  (x1_im),
    .out_last_o (out_last),
    .sat_o      (sat)
  );

  // Round half up when halving: floor((x+1)/2) in plain integer arithmetic.
  function automatic longint halve(input longint x, input bit sc);
    if (!sc) return x;
    if (x + 1 >= 0) return (x + 1) / 2;
    return -((-(x + 1) + 1) / 2);
  endfunction

  function automatic longint clamp32(input longint v, output bit hit);
    hit = 1'b0;
    if (v > 64'sd2147483647) begin
      hit = 1'b1;
      return 64'sd2147483647;
    end
    if (v < -64'sd2147483648) begin
      hit = 1'b1;
      return -64'sd2147483648;
    end
    return v;
  endfunction

  function automatic res_t model(input longint are, input longint aim,
                                 input longint pre, input longint pim, input bit sc);
    res_t r;
    bit h0, h1, h2, h3;
    r.x0re = clamp32(halve(are + pre, sc), h0);
    r.x0im = clamp32(halve(aim + pim, sc), h1);
    r.x1re = clamp32(halve(are - pre, sc), h2);
    r.x1im = clamp32(halve(aim - pim, sc), h3);
    r.sat  = h0 | h1 | h2 | h3;
    return r;
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic signed [31:0] are, input logic signed [31:0] aim,
                               input logic signed [33:0] pre, input logic signed [33:0] pim,
                               input bit sc);
    in_valid = 1'b1;
    a_re     = are;
    a_im     = aim;
    p_re     = pre;
    p_im     = pim;
    scale    = sc;
  endtask

  task automatic doReset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    clr_sat  = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst_out_valid", longint'(out_valid), 0);
    checkOutput("rst_in_ready", longint'(in_ready), 1);
    checkOutput("rst_sat", longint'(sat), 0);
    checkOutput("rst_out_last", longint'(out_last), 0);
    checkOutput("rst_x0_re", longint'(x0_re), 0);
    checkOutput("rst_x1_im", longint'(x1_im), 0);
    rst_n     = 1'b1;
    out_count = 0;
    sat_model = 0;
  endtask

  // One isolated pair through an empty pipeline, checked against a table row.
  task automatic runVector(input vec_t v, input int idx);
    out_ready = 1'b1;
    applyStimulus(v.are, v.aim, v.pre, v.pim, v.sc);
    #1;
    checkOutput($sformatf("v%0d_accept", idx), longint'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput($sformatf("v%0d_s1_only", idx), longint'(out_valid), 0);
    @(posedge clk); #1;
    checkOutput($sformatf("v%0d_valid", idx), longint'(out_valid), 1);
    checkOutput($sformatf("v%0d_x0_re", idx), longint'(x0_re), v.x0re);
    checkOutput($sformatf("v%0d_x0_im", idx), longint'(x0_im), v.x0im);
    checkOutput($sformatf("v%0d_x1_re", idx), longint'(x1_re), v.x1re);
    checkOutput($sformatf("v%0d_x1_im", idx), longint'(x1_im), v.x1im);
    checkOutput($sformatf("v%0d_last", idx), longint'(out_last),
                longint'((out_count % NP) == NP - 1));
    @(posedge clk); #1;
    out_count++;
    checkOutput($sformatf("v%0d_sat", idx), longint'(sat), longint'(v.sat_after));
    checkOutput($sformatf("v%0d_drained", idx), longint'(out_valid), 0);
  endtask

  // Streams n random pairs; bp selects 1010 out_ready with random in_valid.
  task automatic runStream(input int n, input bit bp, input string tag);
    res_t   q[$];
    res_t   exp_r;
    int     sent = 0;
    int     got = 0;
    int     cyc = 0;
    bit     tog = 1'b1;
    bit     exp_ready;
    logic [63:0]        r64;
    logic signed [31:0] rare, raim;
    logic signed [33:0] rpre, rpim;
    bit                 rsc;
    while ((sent < n || got < n) && cyc < 400) begin
      checkOutput({tag, "_sat"}, longint'(sat), longint'(sat_model));
      out_ready = bp ? tog : 1'b1;
      tog = ~tog;
      if (sent < n && (bp ? ($urandom_range(0, 1) == 1) : 1'b1)) begin
        rare = $urandom();
        raim = $urandom();
        r64  = {$urandom(), $urandom()};
        rpre = r64[33:0];
        r64  = {$urandom(), $urandom()};
        rpim = r64[33:0];
        rsc  = $urandom_range(0, 1) == 1;
        applyStimulus(rare, raim, rpre, rpim, rsc);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      exp_ready = !(q.size() == 2 && !out_ready);
      checkOutput({tag, "_in_ready"}, longint'(in_ready), longint'(exp_ready));
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checkOutput({tag, "_spurious_out"}, 1, 0);
        end else begin
          exp_r = q.pop_front();
          checkOutput({tag, "_x0_re"}, longint'(x0_re), exp_r.x0re);
          checkOutput({tag, "_x0_im"}, longint'(x0_im), exp_r.x0im);
          checkOutput({tag, "_x1_re"}, longint'(x1_re), exp_r.x1re);
          checkOutput({tag, "_x1_im"}, longint'(x1_im), exp_r.x1im);
          checkOutput({tag, "_last"}, longint'(out_last),
                      longint'((out_count % NP) == NP - 1));
          sat_model = sat_model | exp_r.sat;
          out_count++;
          got++;
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(longint'(rare), longint'(raim), longint'(rpre),
                          longint'(rpim), rsc));
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    checkOutput({tag, "_count"}, longint'(got), longint'(n));
    if (!bp) checkOutput({tag, "_cycles"}, longint'(cyc), longint'(n + 2));
    checkOutput({tag, "_sat_end"}, longint'(sat), longint'(sat_model));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_sat = 1'b0;
    a_re = '0; a_im = '0; p_re = '0; p_im = '0; scale = 1'b0;

    vecs[0] = '{32'sd100, -32'sd50, 34'sd30, 34'sd20, 1'b0, 130, -30, 70, -70, 1'b0};
    vecs[1] = '{32'sd3, -32'sd3, 34'sd0, 34'sd0, 1'b1, 2, -1, 2, -1, 1'b0};
    vecs[2] = '{32'sd5, 32'sd0, 34'sd2, 34'sd0, 1'b1, 4, 0, 2, 0, 1'b0};
    vecs[3] = '{32'sh7FFF_FFFF, 32'sd0, 34'sh0_7FFF_FFFF, 34'sd0, 1'b0,
                64'sd2147483647, 0, 0, 0, 1'b1};
    vecs[4] = '{32'sh8000_0000, 32'sd0, 34'sh0_8000_0000, 34'sd0, 1'b0,
                0, 0, -64'sd2147483648, 0, 1'b1};
    vecs[5] = '{32'sh7FFF_FFFF, 32'sd0, 34'sh0_7FFF_FFFF, 34'sd0, 1'b1,
                64'sd2147483647, 0, 0, 0, 1'b1};

    doReset();
    for (int i = 0; i < 6; i++) runVector(vecs[i], i);

    clr_sat = 1'b1;
    @(posedge clk); #1;
    clr_sat = 1'b0;
    checkOutput("sat_cleared", longint'(sat), 0);

    // Clear held across a saturated output transfer: the set must win.
    clr_sat = 1'b1;
    runVector(vecs[3], 6);
    @(posedge clk); #1;
    checkOutput("sat_clear_after_set", longint'(sat), 0);
    clr_sat = 1'b0;
    sat_model = 0;

    $display("[TB] backpressure stream");
    runStream(24, 1'b1, "bp");

    $display("[TB] frame marker stream");
    doReset();
    runStream(10, 1'b0, "frame");

    $display("[TB] reset with pairs in flight");
    out_ready = 1'b0;
    applyStimulus(32'sd1, 32'sd2, 34'sd3, 34'sd4, 1'b0);
    @(posedge clk); #1;
    applyStimulus(32'sd5, 32'sd6, 34'sd7, 34'sd8, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("mid_full_valid", longint'(out_valid), 1);
    checkOutput("mid_full_ready", longint'(in_ready), 0);
    doReset();
    runStream(4, 1'b0, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
